// File: rtl/console_pkg.sv
// console_pkg: shared definitions for the console UART.
// Holds the register window offsets, STATUS bit positions and the TX FSM
// state encoding used by console_uart.
package console_pkg;

  // Register offsets inside the 8-byte window.
  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  // STATUS register bit positions.
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 9;
  localparam int ST_OVF       = 31;

  // Transmitter states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/console_fifo.sv
// console_fifo: byte FIFO feeding the UART transmitter.
// Ports:
//   clk, reset (async active-low, clears pointers and count only)
//   push/wdata  - write request; accepted when not full, or when full and a
//                 pop is accepted in the same cycle
//   pop/rdata   - rdata shows the head entry; pop is ignored when empty
//   full, empty, count - occupancy, all derived from the registered count
// Storage is written synchronously and is never reset.
module console_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // empty comes from the registered count, so a byte written this cycle
  // cannot be popped until the following edge.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/console_uart.sv
// console_uart: memory-mapped transmit-only console UART (8N1).
// Ports:
//   clk, reset  - clock and async active-low reset
//   data_addr, data_wdata, data_we - core data-port access (we=0 is a read)
//   data_rdata  - combinational read data for the addressed register
//   hit         - address falls in the 8-byte register window
//   tx          - registered serial output, idle high
// Register map: +0 TXDATA (write pushes a byte), +4 STATUS
//   {ovf[31], count[12:4], empty[2], full[1], busy[0]}; writing bit31 with
//   byte lane 3 enabled clears the sticky overflow flag.
module console_uart
  import console_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_we,
  output logic [31:0] data_rdata,
  output logic        hit,
  output logic        tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              ovf;

  logic              sel_status;
  logic              push;
  logic              pop;
  logic              drop;
  logic              clr_ovf;
  logic              full;
  logic              empty;
  logic              bit_end;
  logic [7:0]        head;
  logic [CNT_W-1:0]  count;
  logic [31:0]       status;
  logic              unused_bits;

  assign unused_bits = ^{data_wdata[30:8], data_we[2:1], data_addr[1:0]};

  // Address decode and register access.
  assign hit        = (data_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_status = (data_addr[2] == OFF_STATUS[2]);
  assign push       = hit && (data_addr[2] == OFF_TXDATA[2]) && data_we[0];
  assign clr_ovf    = hit && sel_status && data_we[3] && data_wdata[31];
  assign pop        = (state == TX_IDLE) && !empty;
  // A push into a full FIFO is only lost if the transmitter is not popping.
  assign drop       = push && full && !pop;
  assign bit_end    = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    status                                = '0;
    status[ST_BUSY]                       = (state != TX_IDLE);
    status[ST_FULL]                       = full;
    status[ST_EMPTY]                      = empty;
    status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(count);
    status[ST_OVF]                        = ovf;
  end

  assign data_rdata = (hit && sel_status) ? status : 32'h0;

  console_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (data_wdata[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  // Shift register: loaded on pop, shifted at the end of each data bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= head;
    end else if ((state == TX_DATA) && bit_end) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  // Transmit FSM. tx is registered and set one state ahead, so each bit
  // appears on the edge that enters its slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          if (!empty) begin
            state <= TX_START;
            tx    <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= TX_DATA;
            tx      <= shreg[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shreg shifts on this same edge, so bit 1 is the next bit.
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= TX_IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_uart.sv
// tb_console_uart: directed bench for console_uart (CLKS_PER_BIT=4,
// FIFO_DEPTH=4) with a queue-based reference model checked every cycle.
module tb_console_uart;

  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_we = 4'h0;
  logic [31:0] data_rdata;
  logic        hit;
  logic        tx;

  int total = 0;
  int bad   = 0;

  console_uart #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_we    (data_we),
    .data_rdata (data_rdata),
    .hit        (hit),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus the frame in flight, timed by the
  // number of cycles elapsed since the frame started.
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h0;
  bit         active = 1'b0;
  int         t = 0;
  bit         m_ovf = 1'b0;

  function automatic logic fbit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic logic m_tx();
    return active ? fbit(cur, t / C) : 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = active;
    s[1]     = (mq.size() == D);
    s[2]     = (mq.size() == 0);
    s[12:4]  = 9'(mq.size());
    s[31]    = m_ovf;
    return s;
  endfunction

  function automatic logic m_hit();
    return data_addr[31:3] == BASE[31:3];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      active = 1'b0;
      t      = 0;
      m_ovf  = 1'b0;
    end else begin
      bit wr;
      bit clr;
      wr  = m_hit() && !data_addr[2] && data_we[0];
      clr = m_hit() && data_addr[2] && data_we[3] && data_wdata[31];
      if (active) begin
        t++;
        if (t == 10 * C) active = 1'b0;
      end else if (mq.size() > 0) begin
        cur    = mq.pop_front();
        active = 1'b1;
        t      = 0;
      end
      if (clr) m_ovf = 1'b0;
      if (wr) begin
        if (mq.size() < D) mq.push_back(data_wdata[7:0]);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the rising edge.
  initial forever begin
    @(negedge clk);
    chk1("model_tx", tx, m_tx());
    chk1("model_hit", hit, m_hit());
    chk("model_rdata", data_rdata, (m_hit() && data_addr[2]) ? m_status() : 32'h0);
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] we);
    data_addr  = a;
    data_wdata = d;
    data_we    = we;
    step();
    data_we    = 4'h0;
    data_wdata = 32'h0;
  endtask

  task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp_d, logic exp_h);
    data_addr = a;
    data_we   = 4'h0;
    #1;
    chk(name, data_rdata, exp_d);
    chk1({name, "_hit"}, hit, exp_h);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] wave_a;
    wave_a = 10'b0100000101;  // 'A' in line order: start, d0..d7, stop

    // Reset state.
    step(2);
    rd_chk("rst_status", BASE + 32'h4, 32'h0000_0004, 1'b1);
    chk1("rst_tx", tx, 1'b1);
    reset = 1'b1;
    step();

    // Idle reads inside and outside the window.
    rd_chk("idle_status", 32'h1000_0004, 32'h0000_0004, 1'b1);
    rd_chk("miss_read", 32'h0000_0100, 32'h0, 1'b0);

    // Single byte 'A'.
    wr(BASE, 32'h0000_0041, 4'b0001);
    chk1("a_pre", tx, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      chk1("a_wave", tx, wave_a[9 - i / C]);
      if (i == 8) rd_chk("a_busy", BASE + 32'h4, 32'h0000_0005, 1'b1);
    end
    step();
    rd_chk("a_done", BASE + 32'h4, 32'h0000_0004, 1'b1);

    // Burst "Hi!" on consecutive cycles.
    data_addr = BASE;
    data_we   = 4'b0001;
    data_wdata = 32'h48; step();
    data_wdata = 32'h69; step();
    data_wdata = 32'h21; step();
    data_we = 4'h0;
    rd_chk("burst_cnt2", BASE + 32'h4, 32'h0000_0021, 1'b1);
    step(39);
    chk1("burst_gap_idle", tx, 1'b1);
    step();
    chk1("burst_next_start", tx, 1'b0);
    rd_chk("burst_cnt1", BASE + 32'h4, 32'h0000_0011, 1'b1);
    step(41);
    chk1("burst_third_start", tx, 1'b0);
    rd_chk("burst_cnt0", BASE + 32'h4, 32'h0000_0005, 1'b1);
    step(41);
    rd_chk("burst_empty", BASE + 32'h4, 32'h0000_0004, 1'b1);

    // Overflow: six stores into a depth-4 FIFO.
    data_addr = BASE;
    data_we   = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      data_wdata = 32'h30 + k;
      step();
    end
    data_we = 4'h0;
    rd_chk("ovf_set", BASE + 32'h4, 32'h8000_0043, 1'b1);
    wr(BASE + 32'h4, 32'h8000_0000, 4'b0111);
    rd_chk("ovf_keep", BASE + 32'h4, 32'h8000_0043, 1'b1);
    wr(BASE + 32'h4, 32'h8000_0000, 4'b1000);
    rd_chk("ovf_clr", BASE + 32'h4, 32'h0000_0043, 1'b1);
    step(5 * 41 + 10);
    rd_chk("ovf_drain", BASE + 32'h4, 32'h0000_0004, 1'b1);

    // Stores that must not push.
    wr(BASE, 32'h0000_0055, 4'b0010);
    data_addr  = BASE + 32'h8;
    data_wdata = 32'h0000_0055;
    data_we    = 4'hF;
    #1;
    chk1("off8_hit", hit, 1'b0);
    step();
    data_we = 4'h0;
    step(5);
    chk1("nopush_tx", tx, 1'b1);
    rd_chk("nopush_status", BASE + 32'h4, 32'h0000_0004, 1'b1);

    // Asynchronous reset during data bit 3 of 0x00.
    wr(BASE, 32'h0000_0000, 4'b0001);
    step(18);
    chk1("pre_rst_tx", tx, 1'b0);
    reset = 1'b0;
    #1;
    chk1("async_rst_tx", tx, 1'b1);
    rd_chk("mid_rst_status", BASE + 32'h4, 32'h0000_0004, 1'b1);
    step(2);
    reset = 1'b1;
    rd_chk("post_rst_status", BASE + 32'h4, 32'h0000_0004, 1'b1);

    // First push right after release.
    wr(BASE, 32'h0000_005A, 4'b0001);
    rd_chk("first_push", BASE + 32'h4, 32'h0000_0010, 1'b1);
    step(45);
    rd_chk("final_status", BASE + 32'h4, 32'h0000_0004, 1'b1);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
